alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: REG_INIT, 8'h00, reset value of all four register-file entries.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  3  operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 mul, 111 reserved.
REQ-007 cmd_srca / cmd_srcb / cmd_dst  input  2 each  register-file indices for operand A, operand B and destination.
REQ-008 cmd_use_imm  input  1  when 1, operand B is cmd_imm instead of register cmd_srcb.
REQ-009 cmd_imm  input  8  immediate operand.
REQ-010 alu_a / alu_b  output  8 each  operands driven to the 8-bit ALU.
REQ-011 alu_opcode  output  3  opcode driven to the ALU, same encoding as cmd_op.
REQ-012 alu_out  input  8  combinational ALU result.
REQ-013 rsp_valid  output  1  result present.
REQ-014 rsp_ready  input  1  consumer accepts result.
REQ-015 rsp_data  output  8  result value.
REQ-016 rsp_zero  output  1  high when rsp_data == 8'h00.
REQ-017 rsp_err  output  1  illegal-opcode flag (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, EXEC and RESP; exactly one command is in flight at a time.
REQ-019 cmd_ready SHALL be high only in IDLE with rst low; a command is accepted on a rising edge with cmd_valid && cmd_ready.
REQ-020 On accept, the block SHALL register alu_a = RF[srca], alu_b = (use_imm ? imm : RF[srcb]) and alu_opcode = cmd_op, latch dst, and go to EXEC.
REQ-021 alu_a, alu_b and alu_opcode SHALL stay stable from the accept edge until the next accept edge.
REQ-022 In EXEC, the next edge SHALL write alu_out into RF[dst] and rsp_data, then go to RESP; rsp_valid SHALL be high from the second edge after accept.
REQ-023 In RESP, rsp_valid SHALL stay high and rsp_data/rsp_zero/rsp_err SHALL hold until an edge with rsp_ready high; that edge SHALL clear rsp_valid and return to IDLE.
REQ-024 The next command SHALL NOT be accepted on the edge on which the response is consumed; minimum spacing between accepts is 3 cycles.
REQ-025 Results SHALL be taken from alu_out unmodified: 8-bit wrap on add/sub and low 8 bits on mul.
REQ-026 srca == dst or srcb == dst SHALL read the old value and write the new value.
REQ-027 cmd_valid while not in IDLE SHALL be ignored, and command inputs SHALL NOT be sampled.
REQ-028 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-029 While rst is high, the block SHALL asynchronously force state IDLE, RF[0..3] = REG_INIT, alu_a = alu_b = 0, alu_opcode = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0 and cmd_ready = 0.
REQ-030 Reset asserted in EXEC or RESP SHALL abort the command without a register write or response; after reset deasserts, cmd_ready SHALL go high with the state in IDLE.

Configuration
REQ-031 Macro ALU_SEQ_ILLEGAL_CHECK_EN defined: an accepted cmd_op == 3'b111 SHALL still take the EXEC/RESP path, SHALL NOT write the register file, and SHALL give rsp_data = 0, rsp_zero = 1 and rsp_err = 1.
REQ-032 Macro ALU_SEQ_ILLEGAL_CHECK_EN undefined: rsp_err SHALL be tied to 0, and opcode 111 SHALL be issued and written back like any other opcode.

Verification
REQ-033 Reset, then cmd add srca=0 imm=0x05 dst=1 -> rsp_data = 0x05, rsp_zero = 0, RF1 = 0x05, rsp_valid high 2 edges after accept.
REQ-034 With RF1 = 0xFF, issue add srca=1 imm=0x01 dst=2 -> rsp_data = 0x00, rsp_zero = 1 (wrap); then mul srca=1 srcb=1 dst=3 -> rsp_data = 0x01.
REQ-035 Hold rsp_ready low for 5 cycles with a new cmd_valid pulsed -> rsp_valid and rsp_data stable, cmd_ready low, second command not accepted.
REQ-036 Assert rst during EXEC of a write to RF2 -> RF2 = REG_INIT after release, no rsp_valid, and cmd_ready = 1 on the first cycle after release.
REQ-037 Issue cmd_op = 111 with dst=0 (RF0 = 0x3C) -> with the macro: rsp_err = 1, rsp_data = 0, RF0 = 0x3C; without the macro: rsp_err = 0 and RF0 = ALU result.
REQ-038 Issue sub srca=1 srcb=1 dst=1 with RF1 = 0x42 -> rsp_data = 0x00 and RF1 = 0x00; a following xor srca=1 imm=0xA5 -> rsp_data = 0xA5.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Issues one register-file command at a time to an external combinational
//   8-bit ALU and returns the result through a valid/ready response port.
//   A 4-entry x 8-bit register file supplies operand A and, unless the
//   immediate is selected, operand B. The same register file receives the
//   result on write-back.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid / cmd_ready        command handshake
//   cmd_op, cmd_srca, cmd_srcb,
//   cmd_dst, cmd_use_imm, cmd_imm command fields
//   alu_a, alu_b, alu_opcode     registered operands/opcode to the ALU
//   alu_out                      combinational ALU result
//   rsp_valid / rsp_ready        response handshake
//   rsp_data, rsp_zero, rsp_err  response payload
//
// Parameter
//   REG_INIT  reset value of every register-file entry
//
// Build option
//   ALU_SEQ_ILLEGAL_CHECK_EN  when defined, opcode 3'b111 is treated as
//   illegal: no write-back, rsp_data = 0, rsp_err = 1. When undefined,
//   rsp_err is tied low and 3'b111 is written back like any other opcode.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// EXEC  | operands held on the ALU, write-back on the next edge
// RESP  | response held until rsp_ready
module alu_sequencer #(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_srca,
  input  logic [1:0] cmd_srcb,
  input  logic [1:0] cmd_dst,
  input  logic       cmd_use_imm,
  input  logic [7:0] cmd_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rf_q [4];
  logic [7:0] rf_d [4];
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [1:0] dst_q, dst_d;
  logic [7:0] rsp_data_q, rsp_data_d;

`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
  logic rsp_err_q, rsp_err_d;
`endif

  // Gated by rst so no command can be taken while reset is still asserted.
  assign cmd_ready  = (state_q == IDLE) && !rst;
  assign rsp_valid  = (state_q == RESP);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = (rsp_data_q == 8'h00);

`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rf_d       = rf_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    dst_d      = dst_q;
    rsp_data_d = rsp_data_q;
`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
    rsp_err_d  = rsp_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d  = rf_q[cmd_srca];
          alu_b_d  = cmd_use_imm ? cmd_imm : rf_q[cmd_srcb];
          alu_op_d = cmd_op;
          dst_d    = cmd_dst;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // Operands were captured at accept, so a source equal to the
        // destination naturally reads the pre-write value.
`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
        if (alu_op_q == 3'b111) begin
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
        end else begin
          rf_d[dst_q] = alu_out;
          rsp_data_d  = alu_out;
          rsp_err_d   = 1'b0;
        end
`else
        rf_d[dst_q] = alu_out;
        rsp_data_d  = alu_out;
`endif
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rf_q       <= '{default: REG_INIT};
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_op_q   <= 3'b000;
      dst_q      <= 2'd0;
      rsp_data_q <= 8'h00;
`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      dst_q      <= dst_d;
      rsp_data_q <= rsp_data_d;
`ifdef ALU_SEQ_ILLEGAL_CHECK_EN
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

endmodule
